div_share_arbiter: RTL and testbench

Shares one Goldschmidt Q4.12 divider among `N_REQ` requesters. Requests are served one at a time in round-robin order. The block captures the granted requester's operands, issues a single-cycle start to the divider, and waits for the divider's valid pulse or a watchdog timeout. It then returns the quotient and error status to the owning requester. It sits between the requesting datapath units and the divider instance, and it is the only driver of the divider's `start` and operand inputs.

---
 rtl/div_share_arbiter.sv | 164 ++++++++++++++++
 tb/tb_div_share_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_share_arbiter
// Brief    : Round-robin sharing of one Q4.12 divider among N_REQ requesters,
//            with a watchdog on the divider's completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module div_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_num,
  input  logic [16*N_REQ-1:0]  req_den,
  output logic [N_REQ-1:0]     req_ack,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [15:0]          rsp_quotient,
  output logic                 rsp_error,
  output logic                 rsp_timeout,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 div_start,
  output logic [15:0]          div_numerator,
  output logic [15:0]          div_denominator,
  input  logic [15:0]          div_quotient,
  input  logic                 div_valid,
  input  logic                 div_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] c_LAST_RST = 3'(N_REQ - 1);
  localparam logic [7:0] c_TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] c_NREQ     = 4'(N_REQ);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_last;
  logic [2:0]  r_gid;
  logic [7:0]  r_tcnt;
  logic [7:0]  w_req_ext;
  logic [7:0]  w_gid_oh;
  logic [3:0]  w_idx;
  logic [2:0]  w_win;
  logic        w_found;
  logic [15:0] w_num_arr [8];
  logic [15:0] w_den_arr [8];

  // Operand slices padded to eight entries so a 3-bit index always fits.
  for (genvar gi = 0; gi < 8; gi++) begin : g_slice
    if (gi < N_REQ) begin : g_used
      assign w_num_arr[gi] = req_num[16*gi +: 16];
      assign w_den_arr[gi] = req_den[16*gi +: 16];
    end else begin : g_unused
      assign w_num_arr[gi] = 16'h0000;
      assign w_den_arr[gi] = 16'h0000;
    end
  end

  assign w_req_ext = 8'(req_valid);
  assign w_gid_oh  = 8'd1 << r_gid;
  assign grant_id  = r_gid;

  // Round-robin search starting just after the last winner, wrapping at N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = 4'd0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = {1'b0, r_last} + 4'(k);
      if (w_idx >= c_NREQ) begin
        w_idx = w_idx - c_NREQ;
      end
      if (!w_found && w_req_ext[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[2:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ack     = '0;
    rsp_valid   = '0;
    div_start   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_found) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start   = 1'b1;
        req_ack     = w_gid_oh[N_REQ-1:0];
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (div_valid || (r_tcnt == c_TO_LAST)) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid   = w_gid_oh[N_REQ-1:0];
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_last          <= c_LAST_RST;
      r_gid           <= 3'd0;
      r_tcnt          <= 8'd0;
      div_numerator   <= 16'h0000;
      div_denominator <= 16'h0000;
      rsp_quotient    <= 16'h0000;
      rsp_error       <= 1'b0;
      rsp_timeout     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_last          <= w_win;
            r_gid           <= w_win;
            div_numerator   <= w_num_arr[w_win];
            div_denominator <= w_den_arr[w_win];
          end
        end
        S_ISSUE: begin
          r_tcnt <= 8'd0;
        end
        S_WAIT: begin
          // A completion on the last watchdog cycle still wins over the timeout.
          if (div_valid) begin
            rsp_quotient <= div_quotient;
            rsp_error    <= div_error;
            rsp_timeout  <= 1'b0;
          end else if (r_tcnt == c_TO_LAST) begin
            rsp_quotient <= 16'h0000;
            rsp_error    <= 1'b1;
            rsp_timeout  <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_share_arbiter
// Brief    : Transaction-schedule model of div_share_arbiter with a stub
//            divider of selectable latency; directed cases then random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_share_arbiter;
  localparam int N     = 4;
  localparam int TO    = 16;
  localparam int NEVER = -1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [16*N-1:0] req_num = '0;
  logic [16*N-1:0] req_den = '0;
  logic [N-1:0]    req_ack, rsp_valid;
  logic [15:0]     rsp_quotient;
  logic            rsp_error, rsp_timeout, busy;
  logic [2:0]      grant_id;
  logic            div_start;
  logic [15:0]     div_numerator, div_denominator;
  logic [15:0]     div_quotient = '0;
  logic            div_valid = 1'b0;
  logic            div_error = 1'b0;

  always #5 clk = ~clk;

  div_share_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_num(req_num), .req_den(req_den),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy),
    .grant_id(grant_id), .div_start(div_start),
    .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_quotient(div_quotient), .div_valid(div_valid), .div_error(div_error)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Requesters: 0 quiet, 1 requesting, 2 acked and awaiting the response.
  int          rq_st  [N] = '{default: 0};
  logic [15:0] rq_num [N] = '{default: 16'h0};
  logic [15:0] rq_den [N] = '{default: 16'h0};
  int          rq_lat [N] = '{default: 1};
  int          dir_seq  [N] = '{default: 0};
  int          dir_seen [N] = '{default: 0};
  logic [15:0] dir_num  [N] = '{default: 16'h0};
  logic [15:0] dir_den  [N] = '{default: 16'h0};
  int          dir_lat  [N] = '{default: 1};
  bit          auto_en = 1'b0;

  // Model: one transaction at a time described by its grant/ack/response cycles.
  bit          m_act = 1'b0;
  int          m_owner = 0, m_last = N-1, m_gid = 0;
  int          m_grant_cyc = 0, m_ack_cyc = 0, m_rsp_cyc = 0;
  int          m_s, m_L, m_win;
  logic [15:0] m_num = '0, m_den = '0, m_q = '0, m_pq = '0;
  logic        m_err = 1'b0, m_to = 1'b0, m_perr = 1'b0, m_pto = 1'b0;
  bit          busy_e, ack_e, rsp_e;

  typedef struct { int at; logic [15:0] q; logic err; } fire_t;
  typedef struct { int cyc; logic [N-1:0] oh; logic [15:0] q; logic err; logic to; } ev_t;
  fire_t fires[$];
  ev_t   acks[$];
  ev_t   rsps[$];
  int    starts[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] qdiv(logic [15:0] n, logic [15:0] d);
    logic [27:0] w;
    if (d == 16'h0) return 16'h0;
    w = {n, 12'h000} / {12'h000, d};
    return w[15:0];
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 19));
    case (r)
      0: return NEVER;
      1: return TO;
      2: return TO + 1;
      3: return TO + 2;
      4: return TO + 3;
      default: return int'($urandom_range(1, 8));
    endcase
  endfunction

  function automatic bit quiet();
    if (fires.size() != 0) return 1'b0;
    if (m_act && cyc <= m_rsp_cyc) return 1'b0;
    for (int i = 0; i < N; i++)
      if (rq_st[i] != 0 || dir_seq[i] != dir_seen[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_last = N-1; m_gid = 0; m_owner = 0;
    m_num = '0; m_den = '0; m_q = '0; m_err = 1'b0; m_to = 1'b0;
    fires.delete();
    for (int i = 0; i < N; i++) rq_st[i] = 0;
  endtask

  // Compare, then drive this cycle's inputs, then advance the model on them.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      model_reset();
      check("reset_outputs", {req_ack, rsp_valid, rsp_quotient, rsp_error, rsp_timeout, busy,
                              grant_id, div_start, div_numerator, div_denominator}, 64'h0);
      req_valid = '0; req_num = '0; req_den = '0;
      div_valid = 1'b0; div_quotient = '0; div_error = 1'b0;
    end else begin
      busy_e = m_act && cyc > m_grant_cyc && cyc <= m_rsp_cyc;
      ack_e  = m_act && cyc == m_ack_cyc;
      rsp_e  = m_act && cyc == m_rsp_cyc;
      if (rsp_e) begin m_q = m_pq; m_err = m_perr; m_to = m_pto; end
      check("busy", busy, busy_e);
      check("req_ack", req_ack, ack_e ? onehot(m_owner) : '0);
      check("div_start", div_start, ack_e);
      check("rsp_valid", rsp_valid, rsp_e ? onehot(m_owner) : '0);
      check("grant_id", grant_id, 3'(m_gid));
      check("div_operands", {div_numerator, div_denominator}, {m_num, m_den});
      check("rsp_fields", {rsp_quotient, rsp_error, rsp_timeout}, {m_q, m_err, m_to});
      if (req_ack != '0) acks.push_back('{cyc, req_ack, 16'h0, 1'b0, 1'b0});
      if (div_start) starts.push_back(cyc);
      if (rsp_valid != '0) rsps.push_back('{cyc, rsp_valid, rsp_quotient, rsp_error, rsp_timeout});
      if (ack_e) rq_st[m_owner] = 2;
      if (rsp_e) rq_st[m_owner] = 0;

      for (int i = 0; i < N; i++) begin
        if (rq_st[i] == 0) begin
          if (dir_seq[i] != dir_seen[i]) begin
            dir_seen[i] = dir_seq[i];
            rq_num[i] = dir_num[i]; rq_den[i] = dir_den[i]; rq_lat[i] = dir_lat[i];
            rq_st[i] = 1;
          end else if (auto_en && $urandom_range(0, 5) == 0) begin
            rq_num[i] = 16'($urandom);
            rq_den[i] = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
            rq_lat[i] = pick_lat();
            rq_st[i] = 1;
          end
        end else if (rq_st[i] == 1 && auto_en && $urandom_range(0, 19) == 0) begin
          rq_st[i] = 0;
        end
        req_valid[i] = (rq_st[i] == 1);
        req_num[16*i +: 16] = (rq_st[i] == 1) ? rq_num[i] : 16'($urandom);
        req_den[16*i +: 16] = (rq_st[i] == 1) ? rq_den[i] : 16'($urandom);
      end
      div_valid = 1'b0; div_quotient = 16'($urandom); div_error = 1'($urandom);
      if (fires.size() != 0 && fires[0].at == cyc) begin
        div_valid = 1'b1; div_quotient = fires[0].q; div_error = fires[0].err;
        void'(fires.pop_front());
      end

      if (!busy_e && req_valid != '0) begin
        m_win = 0;
        for (int k = 1; k <= N; k++) begin
          if (req_valid[(m_last + k) % N]) begin m_win = (m_last + k) % N; break; end
        end
        m_act = 1'b1; m_owner = m_win; m_last = m_win; m_gid = m_win;
        m_num = rq_num[m_win]; m_den = rq_den[m_win];
        m_grant_cyc = cyc; m_ack_cyc = cyc + 1; m_s = cyc + 1; m_L = rq_lat[m_win];
        if (m_L != NEVER) fires.push_back('{m_s + m_L, qdiv(m_num, m_den), m_den == 16'h0});
        if (m_L != NEVER && m_L <= TO) begin
          m_rsp_cyc = m_s + m_L + 1; m_pq = qdiv(m_num, m_den); m_perr = (m_den == 16'h0); m_pto = 1'b0;
        end else begin
          m_rsp_cyc = m_s + TO + 1; m_pq = 16'h0; m_perr = 1'b1; m_pto = 1'b1;
        end
      end
    end
  end

  task automatic req(int i, logic [15:0] n, logic [15:0] d, int lat);
    dir_num[i] = n; dir_den[i] = d; dir_lat[i] = lat;
    dir_seq[i] = dir_seq[i] + 1;
  endtask

  task automatic wait_quiet(string tag);
    int n;
    n = 0;
    do begin @(posedge clk); n++; end while (!quiet() && n < 3000);
    check({tag, "_drain"}, quiet(), 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int a0, r0, s0, n;
  logic [15:0] exp_q [4];

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", {busy, req_ack, rsp_valid, div_start, grant_id, rsp_error}, 64'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request from requester 2.
    a0 = acks.size(); r0 = rsps.size();
    req(2, 16'h3000, 16'h1800, 5);
    wait_quiet("single");
    check("single_ack_count", acks.size() - a0, 1);
    check("single_ack_oh", acks[a0].oh, 4'b0100);
    check("single_rsp_oh", rsps[r0].oh, 4'b0100);
    check("single_q_range", (rsps[r0].q >= 16'h1FFE && rsps[r0].q <= 16'h2002), 1'b1);
    check("single_err", rsps[r0].err, 1'b0);
    check("single_ack_to_rsp", rsps[r0].cyc - acks[a0].cyc, 6);

    // All four together from reset.
    do_reset();
    a0 = acks.size(); r0 = rsps.size();
    exp_q = '{16'h1000, 16'h2000, 16'h0800, 16'h3000};
    req(0, 16'h1000, 16'h1000, 3); req(1, 16'h2000, 16'h1000, 3);
    req(2, 16'h1000, 16'h2000, 3); req(3, 16'h3000, 16'h1000, 3);
    wait_quiet("simul");
    check("simul_rsp_count", rsps.size() - r0, 4);
    for (int k = 0; k < 4; k++) begin
      check("simul_ack_order", acks[a0+k].oh, onehot(k));
      check("simul_rsp_owner", rsps[r0+k].oh, onehot(k));
      check("simul_rsp_q", rsps[r0+k].q, exp_q[k]);
      if (k > 0) check("simul_start_gap", acks[a0+k].cyc - acks[a0+k-1].cyc, 6);
    end

    // Wrap: last owner is 3, so 0 beats 3.
    a0 = acks.size();
    req(0, 16'h0400, 16'h1000, 2); req(3, 16'h0C00, 16'h1000, 2);
    wait_quiet("wrap");
    check("wrap_first", acks[a0].oh, 4'b0001);
    check("wrap_second", acks[a0+1].oh, 4'b1000);

    // Divide by zero.
    r0 = rsps.size();
    req(1, 16'h1000, 16'h0000, 4);
    wait_quiet("div0");
    check("div0_rsp", {rsps[r0].oh, rsps[r0].q, rsps[r0].err, rsps[r0].to}, {4'b0010, 16'h0, 1'b1, 1'b0});

    // Watchdog, then a pending request served normally.
    a0 = acks.size(); r0 = rsps.size(); s0 = starts.size();
    req(2, 16'h1234, 16'h0100, NEVER);
    repeat (5) @(posedge clk); #1;
    req(3, 16'h0800, 16'h1000, 2);
    wait_quiet("timeout");
    check("timeout_latency", rsps[r0].cyc - starts[s0], 17);
    check("timeout_rsp", {rsps[r0].oh, rsps[r0].q, rsps[r0].err, rsps[r0].to}, {4'b0100, 16'h0, 1'b1, 1'b1});
    check("after_timeout_ack", acks[a0+1].oh, 4'b1000);
    check("after_timeout_ack_cyc", acks[a0+1].cyc - rsps[r0].cyc, 2);
    check("after_timeout_rsp", {rsps[r0+1].q, rsps[r0+1].err}, {16'h0800, 1'b0});

    // Reset while waiting on the divider.
    s0 = starts.size(); r0 = rsps.size();
    req(1, 16'h1000, 16'h1000, NEVER);
    n = 0;
    while (starts.size() == s0 && n < 50) begin @(posedge clk); n++; end
    check("midwait_started", starts.size() > s0, 1'b1);
    repeat (5) @(posedge clk);
    #1 check("midwait_busy", busy, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("midwait_reset_outputs", {req_ack, rsp_valid, busy, div_start, grant_id, div_numerator,
                                       div_denominator, rsp_quotient, rsp_error, rsp_timeout}, 64'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check("midwait_no_rsp", rsps.size() - r0, 0);
    @(posedge clk); #1;
    a0 = acks.size();
    req(2, 16'h2000, 16'h2000, 3); req(0, 16'h1000, 16'h2000, 3);
    wait_quiet("midwait");
    check("midwait_first", acks[a0].oh, 4'b0001);
    check("midwait_second", acks[a0+1].oh, 4'b0100);
    check("midwait_rsp_count", rsps.size() - r0, 2);

    // Random traffic with withdrawals, late completions and zero divisors.
    auto_en = 1'b1;
    repeat (5000) @(posedge clk);
    #1 auto_en = 1'b0;
    wait_quiet("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
